sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Two-to-one arbiter that shares a single downstream sram-like port between the instruction-side sram-like master (inst_*, from the sram-to-sram-like bridge) and the data-side sram-like master (data_*). One transaction outstanding at a time; grant held from address phase until data_ok. Sits between the CPU's two bridges and the AXI/cache interface.

## Interface
Parameters:
- none (widths fixed: 32-bit addr/data, 2-bit size)

Ports (clock and reset first):
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- inst_req / inst_wr  in  1 / 1  inst master request, write flag
- inst_size  in  2  transfer size
- inst_addr / inst_wdata  in  32 / 32  address, write data
- inst_addr_ok / inst_data_ok  out  1 / 1  handshakes routed to inst master
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as inst_* for data master
- mem_req / mem_wr  out  1 / 1  downstream request, write flag
- mem_size  out  2;  mem_addr / mem_wdata  out  32 / 32
- mem_addr_ok / mem_data_ok  in  1 / 1  downstream handshakes
- mem_rdata  in  32  downstream read data
- owner  out  1  current/last grant: 0 = inst, 1 = data

## Operation
- State machine: IDLE, ADDR, DATA (2-bit state reg).
- IDLE: if inst_req | data_req, pick winner, register into owner, go ADDR. Else stay.
- Winner (no macro): data wins whenever data_req = 1.
- ADDR: mem_req = 1; mem_wr/size/addr/wdata muxed from owner's inputs (masters hold them stable while req high). owner's *_addr_ok = mem_addr_ok; other master's addr_ok = 0.
  - mem_addr_ok & mem_data_ok same cycle: forward both to owner, go IDLE.
  - mem_addr_ok only: go DATA.
  - neither: stay ADDR.
- DATA: mem_req = 0. owner's *_data_ok = mem_data_ok; on mem_data_ok go IDLE.
- mem_data_ok never forwarded in IDLE; a stray mem_data_ok in IDLE is ignored.
- inst_rdata = data_rdata = mem_rdata always (qualified by data_ok).
- Loser's req stays pending; no addr_ok to it until granted later.
- Owner's req dropping in ADDR before addr_ok is a protocol violation; behaviour undefined.

## Timing
- Reset: state = IDLE, owner = 0; mem_req, all *_addr_ok, all *_data_ok = 0.
- Reset mid-transaction: next cycle IDLE, all outputs as above; in-flight downstream transaction abandoned (downstream also reset).
- Grant latency: req seen in IDLE at cycle N -> mem_req high at cycle N+1.
- addr_ok and data_ok forwarded combinationally, same cycle as mem_*_ok.
- Minimum transaction: 2 cycles (IDLE, ADDR with both oks); back-to-back next grant evaluated in following IDLE cycle, so one idle cycle between transactions.
- mem_req never asserted in IDLE or DATA.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous inst_req & data_req in IDLE, grant the master not equal to owner (last granted); single request granted directly.
- Undefined: fixed priority, data over inst, regardless of owner.

## Test plan
- Reset then inst_req=1, addr 0xBFC00000, mem_addr_ok at cycle 2, mem_data_ok with rdata 0x24080001 at cycle 4 -> mem_addr=0xBFC00000 cycle 1-2, inst_addr_ok cycle 2, inst_data_ok & inst_rdata=0x24080001 cycle 4, data_* oks stay 0.
- inst_req & data_req both held, data_wr=1 addr 0x80000010 wdata 0xDEADBEEF -> first mem_req carries data fields, owner=1; inst served next transaction; with ARB_ROUND_ROBIN_EN and owner=1 beforehand, inst served first instead.
- Downstream returns mem_addr_ok & mem_data_ok same cycle -> owner gets both same cycle, state back to IDLE next cycle, no DATA state visited.
- mem_addr_ok held low 5 cycles -> mem_req held, fields stable, no addr_ok forwarded until it rises.
- rst asserted while in DATA -> next cycle mem_req=0, all oks 0, owner=0; later mem_data_ok pulse ignored.
- Stray mem_data_ok in IDLE with no req -> inst_data_ok = data_data_ok = 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one downstream sram-like port between the
// instruction-side and data-side sram-like masters. One transaction is
// outstanding at a time; the grant is held from address phase to data_ok.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests alternate against the last grant
//   undefined -> fixed priority, data master over inst master
module sram_like_arbiter (
  input  logic        clk,
  input  logic        rst,
  // instruction-side master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data-side master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // downstream port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  // current/last grant: 0 = inst, 1 = data
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   grant_data;

`ifdef ARB_ROUND_ROBIN_EN
  // Winner selection: contention goes to the master not granted last time
  always_comb begin
    if (inst_req && data_req) begin
      grant_data = ~owner_q;
    end else begin
      grant_data = data_req;
    end
  end
`else
  // Winner selection: data master always wins when it is requesting
  always_comb begin
    grant_data = data_req;
  end
`endif

  // State and owner registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic: grant in IDLE, hold through address and data phases
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (inst_req || data_req) begin
          owner_d = grant_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (mem_addr_ok && mem_data_ok) begin
          state_d = S_IDLE;
        end else if (mem_addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output routing: request fields from the owner, handshakes back to it only
  always_comb begin
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_wr       = owner_q ? data_wr    : inst_wr;
    mem_size     = owner_q ? data_size  : inst_size;
    mem_addr     = owner_q ? data_addr  : inst_addr;
    mem_wdata    = owner_q ? data_wdata : inst_wdata;
    case (state_q)
      S_ADDR: begin
        mem_req = 1'b1;
        // data_ok in the address phase only counts alongside addr_ok
        if (owner_q) begin
          data_addr_ok = mem_addr_ok;
          data_data_ok = mem_addr_ok & mem_data_ok;
        end else begin
          inst_addr_ok = mem_addr_ok;
          inst_data_ok = mem_addr_ok & mem_data_ok;
        end
      end
      S_DATA: begin
        if (owner_q) begin
          data_data_ok = mem_data_ok;
        end else begin
          inst_data_ok = mem_data_ok;
        end
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; masters qualify it with their data_ok
  always_comb begin
    inst_rdata = mem_rdata;
    data_rdata = mem_rdata;
    owner      = owner_q;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter. Expected downstream requests are
// pushed to a scoreboard queue when a master is driven and popped when the
// downstream accepts an address phase.
module tb_sram_like_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        owner;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        own;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  sram_like_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_inst();
    txn_t t;
    t.wr = inst_wr; t.size = inst_size; t.addr = inst_addr; t.wdata = inst_wdata; t.own = 1'b0;
    sb.push_back(t);
  endtask

  task automatic push_data();
    txn_t t;
    t.wr = data_wr; t.size = data_size; t.addr = data_addr; t.wdata = data_wdata; t.own = 1'b1;
    sb.push_back(t);
  endtask

  // Compare the presented downstream request against the scoreboard head
  task automatic cmp_fields(input string tag, input txn_t e);
    chk({tag, "_mem_req"},   {31'd0, mem_req}, 32'd1);
    chk({tag, "_mem_wr"},    {31'd0, mem_wr}, {31'd0, e.wr});
    chk({tag, "_mem_size"},  {30'd0, mem_size}, {30'd0, e.size});
    chk({tag, "_mem_addr"},  mem_addr, e.addr);
    chk({tag, "_mem_wdata"}, mem_wdata, e.wdata);
    chk({tag, "_owner"},     {31'd0, owner}, {31'd0, e.own});
  endtask

  // One full transaction starting from an IDLE cycle with requests driven
  task automatic run_txn(input string tag, input int unsigned waits,
                         input bit combined, input logic [31:0] rdata);
    txn_t e;
    settle();
    chk({tag, "_idle_req"}, {31'd0, mem_req}, 32'd0);
    tick();
    for (int unsigned i = 0; i < waits; i++) begin
      settle();
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        cmp_fields({tag, "_wait"}, sb[0]);
      end
      chk({tag, "_wait_aok"}, {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1;
    mem_data_ok = combined;
    mem_rdata   = rdata;
    settle();
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    cmp_fields({tag, "_acc"}, e);
    chk({tag, "_aok"}, {30'd0, inst_addr_ok, data_addr_ok}, e.own ? 32'd1 : 32'd2);
    if (combined) begin
      chk({tag, "_dok_comb"}, {30'd0, inst_data_ok, data_data_ok}, e.own ? 32'd1 : 32'd2);
      chk({tag, "_rdata_comb"}, e.own ? data_rdata : inst_rdata, rdata);
    end
    tick();
    if (e.own) data_req = 1'b0; else inst_req = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (!combined) begin
      settle();
      chk({tag, "_data_noreq"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_data_wait_dok"}, {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      tick();
      mem_data_ok = 1'b1;
      settle();
      chk({tag, "_dok"}, {30'd0, inst_data_ok, data_data_ok}, e.own ? 32'd1 : 32'd2);
      chk({tag, "_rdata"}, e.own ? data_rdata : inst_rdata, rdata);
      tick();
      mem_data_ok = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);

    // Single inst read, addr_ok after one wait cycle, data one cycle later
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
    push_inst();
    run_txn("inst_rd", 1, 1'b0, 32'h2408_0001);
    settle();
    chk("post_inst_idle", {31'd0, mem_req}, 32'd0);

    // Contention: data wins first (owner was inst), inst afterwards
    inst_req = 1'b1; inst_addr = 32'h1FC0_0100;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    push_data();
    push_inst();
    run_txn("both_1st", 0, 1'b0, 32'h0000_0000);
    run_txn("both_2nd", 0, 1'b0, 32'h1111_2222);

    // Data-only transaction leaves owner = data, then contention again
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0040;
    push_data();
    run_txn("data_only", 0, 1'b1, 32'h3333_4444);
    settle();
    chk("owner_after_data", {31'd0, owner}, 32'd1);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_addr = 32'h8000_0080; data_size = 2'd1;
`ifdef ARB_ROUND_ROBIN_EN
    push_inst();
    push_data();
`else
    push_data();
    push_inst();
`endif
    run_txn("rr_1st", 0, 1'b1, 32'h5555_6666);
    run_txn("rr_2nd", 0, 1'b1, 32'h7777_8888);

    // Combined oks: next cycle must be IDLE, so a data_ok pulse is ignored
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    push_inst();
    run_txn("comb", 0, 1'b1, 32'hCAFE_0001);
    mem_data_ok = 1'b1;
    settle();
    chk("comb_no_data_state", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b0;

    // Slow addr_ok: request and fields held for five cycles
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h8000_0100; data_wdata = 32'h0000_00A5;
    push_data();
    run_txn("slow", 5, 1'b0, 32'h0);

    // Reset while in DATA abandons the transaction
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0200;
    push_data();
    settle();
    tick();
    mem_addr_ok = 1'b1;
    settle();
    if (sb.size() != 0) begin
      cmp_fields("rstd_acc", sb.pop_front());
    end else begin
      chk("rstd_sb_empty", 32'd0, 32'd1);
    end
    tick();
    data_req = 1'b0;
    mem_addr_ok = 1'b0;
    settle();
    chk("rstd_in_data", {31'd0, owner}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rstd_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstd_owner", {31'd0, owner}, 32'd0);
    chk("rstd_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    mem_data_ok = 1'b1;
    settle();
    chk("rstd_late_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    tick();

    // Stray data_ok in IDLE with no request pending
    settle();
    chk("stray_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    mem_data_ok = 1'b0;
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
